// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Shares one external combinational ALU between two requesters. Port 0 is
//   the integer pipeline and port 1 is the branch/address helper. A request is
//   granted round-robin in IDLE. It is then held on the ALU inputs for SETTLE
//   cycles in EXEC. The ALU result is captured into the owner's response
//   register and presented in RESP until the owner consumes it.
//
// Parameters:
//   XLEN    operand/result width (default 32)
//   SETTLE  cycles the ALU inputs are held before capture (legal 1..15)
//
// Ports:
//   clk, reset_n                 clock (rising edge), synchronous active-low reset
//   reqN_valid / reqN_ready      request handshake; ready is combinational in IDLE
//   reqN_ctrl, reqN_a, reqN_b    4-bit ALU control code and operands
//   respN_valid / respN_ready    response handshake towards requester N
//   respN_data                   captured result; holds its value while valid is low
//   respN_err                    illegal-code flag (only with ALU_SHARE_ARB_ERR_EN)
//   alu_ctrl, alu_a, alu_b       registered drive to the shared ALU
//   alu_result                   combinational result from the shared ALU
//
// Configuration:
//   `define ALU_SHARE_ARB_ERR_EN adds the respN_err outputs. Without it, an
//   illegal code (1010..1111) still yields a zero result, but nothing flags it.
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int XLEN   = 32,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            reset_n,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [3:0]      req0_ctrl,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    output logic            resp0_valid,
    input  logic            resp0_ready,
    output logic [XLEN-1:0] resp0_data,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [3:0]      req1_ctrl,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic            resp1_valid,
    input  logic            resp1_ready,
    output logic [XLEN-1:0] resp1_data,

`ifdef ALU_SHARE_ARB_ERR_EN
    output logic            resp0_err,
    output logic            resp1_err,
`endif

    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result
);

    localparam logic [3:0] CTRL_ADD        = 4'b0010;
    localparam logic [3:0] CTRL_LAST_LEGAL = 4'b1001;
    localparam logic [3:0] SETTLE_INIT     = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            prio;
    logic            owner;
    logic [3:0]      cnt;

    logic            any_valid;
    logic            grant_port;
    logic            grant_fire;
    logic            capture;
    logic            resp_done;
    logic            owner_resp_ready;
    logic            illegal;
    logic [XLEN-1:0] captured;

    // The issue register drives the ALU, so the code being captured is the
    // one that is checked for legality. An illegal code still reaches the ALU
    // unchanged. Only the captured result is forced to zero.
    assign illegal  = (alu_ctrl > CTRL_LAST_LEGAL);
    assign captured = illegal ? '0 : alu_result;

    // Next-state and handshake decode. When both ports are valid, the grant
    // goes to the port named by prio. Otherwise it goes to the only valid
    // port. Ready is also gated by reset_n, so no handshake can complete
    // while the block is held in reset.
    always_comb begin
        next_state       = state;
        req0_ready       = 1'b0;
        req1_ready       = 1'b0;
        grant_fire       = 1'b0;
        capture          = 1'b0;
        resp_done        = 1'b0;
        any_valid        = req0_valid | req1_valid;
        grant_port       = (req0_valid & req1_valid) ? prio : req1_valid;
        owner_resp_ready = owner ? resp1_ready : resp0_ready;

        case (state)
            IDLE: begin
                if (reset_n && any_valid) begin
                    grant_fire = 1'b1;
                    req0_ready = ~grant_port;
                    req1_ready = grant_port;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (owner_resp_ready) begin
                    resp_done  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath. A grant loads the issue register and the settle counter and
    // hands priority to the other port. A capture moves the ALU result into
    // the owner's response register. The response register keeps its data
    // after the handshake, so only valid is cleared. A reset in mid-operation
    // drops the operation and restores priority to port 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prio        <= 1'b0;
            owner       <= 1'b0;
            cnt         <= 4'd0;
            alu_ctrl    <= CTRL_ADD;
            alu_a       <= '0;
            alu_b       <= '0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp0_data  <= '0;
            resp1_data  <= '0;
        end else begin
            if (grant_fire) begin
                owner    <= grant_port;
                prio     <= ~grant_port;
                cnt      <= SETTLE_INIT;
                alu_ctrl <= grant_port ? req1_ctrl : req0_ctrl;
                alu_a    <= grant_port ? req1_a    : req0_a;
                alu_b    <= grant_port ? req1_b    : req0_b;
            end else if (state == EXEC && !capture) begin
                cnt <= cnt - 4'd1;
            end

            if (capture) begin
                if (owner) begin
                    resp1_valid <= 1'b1;
                    resp1_data  <= captured;
                end else begin
                    resp0_valid <= 1'b1;
                    resp0_data  <= captured;
                end
            end

            if (resp_done) begin
                if (owner) begin
                    resp1_valid <= 1'b0;
                end else begin
                    resp0_valid <= 1'b0;
                end
            end
        end
    end

`ifdef ALU_SHARE_ARB_ERR_EN
    // The error flags follow the owner's response valid. A flag is set at
    // capture when the issued code was illegal and cleared when the owner
    // consumes the response.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            resp0_err <= 1'b0;
            resp1_err <= 1'b0;
        end else begin
            if (capture) begin
                if (owner) begin
                    resp1_err <= illegal;
                end else begin
                    resp0_err <= illegal;
                end
            end
            if (resp_done) begin
                if (owner) begin
                    resp1_err <= 1'b0;
                end else begin
                    resp0_err <= 1'b0;
                end
            end
        end
    end
`else
    // Without the error flags, an illegal code shows up only as a zero result.
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Self-checking bench for alu_share_arbiter. It has two instances: u_dut
// uses SETTLE=1 and u_dut4 uses SETTLE=4. Each instance drives its own
// combinational ALU model.
//
// Expected results are hand-computed constants in a vector table. A vector's
// result is pushed to a scoreboard queue when its request handshake completes,
// and it is popped and compared when the matching response handshake occurs.
// The ALU model returns a nonzero pattern for illegal codes. The arbiter must
// replace that pattern with zero.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int XLEN = 32;

    typedef struct {
        int          port;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
    } sb_t;

    logic clk = 1'b0;
    logic reset_n;

    logic            req0_valid, req0_ready, resp0_valid, resp0_ready;
    logic [3:0]      req0_ctrl;
    logic [XLEN-1:0] req0_a, req0_b, resp0_data;
    logic            req1_valid, req1_ready, resp1_valid, resp1_ready;
    logic [3:0]      req1_ctrl;
    logic [XLEN-1:0] req1_a, req1_b, resp1_data;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;

    logic            s4_req0_valid, s4_req0_ready, s4_resp0_valid, s4_resp0_ready;
    logic [3:0]      s4_req0_ctrl;
    logic [XLEN-1:0] s4_req0_a, s4_req0_b, s4_resp0_data;
    logic            s4_req1_valid, s4_req1_ready, s4_resp1_valid, s4_resp1_ready;
    logic [3:0]      s4_req1_ctrl;
    logic [XLEN-1:0] s4_req1_a, s4_req1_b, s4_resp1_data;
    logic [3:0]      s4_alu_ctrl;
    logic [XLEN-1:0] s4_alu_a, s4_alu_b, s4_alu_result;

`ifdef ALU_SHARE_ARB_ERR_EN
    logic err0, err1, s4_err0, s4_err1;
`endif

    int   checks = 0;
    int   errors = 0;
    sb_t  sbQ[$];
    int   grantLog[$];
    sb_t  pend0, pend1;
    vec_t vecs[12];

    always #5 clk = ~clk;

    // Stand-in for the shared combinational ALU.
    function automatic logic [31:0] aluModel(input logic [3:0] c, input logic [31:0] a,
                                             input logic [31:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a ^ b;
            4'b0100: return a << b[4:0];
            4'b0101: return a >> b[4:0];
            4'b0110: return a - b;
            4'b0111: return {31'b0, $signed(a) < $signed(b)};
            4'b1000: return {31'b0, a < b};
            4'b1001: return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_result    = aluModel(alu_ctrl, alu_a, alu_b);
    assign s4_alu_result = aluModel(s4_alu_ctrl, s4_alu_a, s4_alu_b);

    alu_share_arbiter #(.XLEN(XLEN), .SETTLE(1)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_a(req0_a), .req0_b(req0_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
`ifdef ALU_SHARE_ARB_ERR_EN
        .resp0_err(err0), .resp1_err(err1),
`endif
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result)
    );

    alu_share_arbiter #(.XLEN(XLEN), .SETTLE(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(s4_req0_valid), .req0_ready(s4_req0_ready), .req0_ctrl(s4_req0_ctrl),
        .req0_a(s4_req0_a), .req0_b(s4_req0_b),
        .resp0_valid(s4_resp0_valid), .resp0_ready(s4_resp0_ready), .resp0_data(s4_resp0_data),
        .req1_valid(s4_req1_valid), .req1_ready(s4_req1_ready), .req1_ctrl(s4_req1_ctrl),
        .req1_a(s4_req1_a), .req1_b(s4_req1_b),
        .resp1_valid(s4_resp1_valid), .resp1_ready(s4_resp1_ready), .resp1_data(s4_resp1_data),
`ifdef ALU_SHARE_ARB_ERR_EN
        .resp0_err(s4_err0), .resp1_err(s4_err1),
`endif
        .alu_ctrl(s4_alu_ctrl), .alu_a(s4_alu_a), .alu_b(s4_alu_b), .alu_result(s4_alu_result)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Pops the oldest expected response and compares it with the one the
    // DUT just handed over.
    task automatic checkResponse(input int port, input logic [31:0] data);
        sb_t e;
        checks++;
        if (sbQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL resp_unexpected: port %0d gave %h, expected no response", port, data);
            return;
        end
        e = sbQ.pop_front();
        if (e.port != port) begin
            errors++;
            $display("[TB] FAIL resp_owner: got port %0d, expected port %0d", port, e.port);
        end else if (data !== e.data) begin
            errors++;
            $display("[TB] FAIL resp%0d_data: got %h, expected %h", port, data, e.data);
        end
`ifdef ALU_SHARE_ARB_ERR_EN
        checks++;
        if ((port == 0 ? err0 : err1) !== e.err) begin
            errors++;
            $display("[TB] FAIL resp%0d_err: got %b, expected %b", port,
                     (port == 0 ? err0 : err1), e.err);
        end
`endif
    endtask

    // Monitor: pushes on request handshakes and checks on response handshakes.
    always @(negedge clk) begin
        if (reset_n) begin
            if (req0_valid && req0_ready) begin
                sbQ.push_back(pend0);
                grantLog.push_back(0);
            end
            if (req1_valid && req1_ready) begin
                sbQ.push_back(pend1);
                grantLog.push_back(1);
            end
            if (resp0_valid && resp0_ready) checkResponse(0, resp0_data);
            if (resp1_valid && resp1_ready) checkResponse(1, resp1_data);
        end
    end

    task automatic applyStimulus(input int port, input logic [3:0] ctrl, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp, input logic err);
        if (port == 0) begin
            pend0      = '{0, exp, err};
            req0_ctrl  = ctrl;
            req0_a     = a;
            req0_b     = b;
            req0_valid = 1'b1;
        end else begin
            pend1      = '{1, exp, err};
            req1_ctrl  = ctrl;
            req1_a     = a;
            req1_b     = b;
            req1_valid = 1'b1;
        end
    endtask

    // Waits for the port's ready, then drops valid just after the handshake edge.
    task automatic waitGrant(input int port, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (port == 0 ? req0_ready : req1_ready) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL grant_timeout: port %0d got no ready within %0d cycles", port, budget);
        end
        @(posedge clk);
        #1;
        if (port == 0) req0_valid = 1'b0;
        else           req1_valid = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            if (sbQ.size() == 0) done = 1'b1;
        end
        #1;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending responses, expected 0", sbQ.size());
        end
    endtask

    task automatic checkGrantOrder(input string name, input int exp0, input int exp1);
        checkOutput({name, "_count"}, grantLog.size(), 2);
        if (grantLog.size() >= 2) begin
            checkOutput({name, "_first"}, grantLog[0], exp0);
            checkOutput({name, "_second"}, grantLog[1], exp1);
        end
        grantLog.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{0, 4'b0010, 32'd5,          32'd7,          32'd12,         1'b0};
        vecs[1]  = '{1, 4'b0110, 32'd10,         32'd3,          32'd7,          1'b0};
        vecs[2]  = '{0, 4'b0000, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0,  1'b0};
        vecs[3]  = '{1, 4'b0001, 32'h0000_1200,  32'h0000_0034,  32'h0000_1234,  1'b0};
        vecs[4]  = '{0, 4'b0011, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'hF0F0_0F0F,  1'b0};
        vecs[5]  = '{1, 4'b0100, 32'h0000_0001,  32'd31,         32'h8000_0000,  1'b0};
        vecs[6]  = '{0, 4'b0101, 32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0};
        vecs[7]  = '{1, 4'b0111, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0};
        vecs[8]  = '{0, 4'b1000, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
        vecs[9]  = '{1, 4'b1001, 32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0};
        vecs[10] = '{0, 4'b1100, 32'd5,          32'd7,          32'd0,          1'b1};
        vecs[11] = '{1, 4'b1111, 32'h1234_5678,  32'd1,          32'd0,          1'b1};

        reset_n     = 1'b0;
        req0_valid  = 1'b0; req0_ctrl = 4'd0; req0_a = '0; req0_b = '0;
        req1_valid  = 1'b0; req1_ctrl = 4'd0; req1_a = '0; req1_b = '0;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        s4_req0_valid = 1'b0; s4_req0_ctrl = 4'd0; s4_req0_a = '0; s4_req0_b = '0;
        s4_req1_valid = 1'b0; s4_req1_ctrl = 4'd0; s4_req1_a = '0; s4_req1_b = '0;
        s4_resp0_ready = 1'b1;
        s4_resp1_ready = 1'b1;
        pend0 = '{0, 32'd0, 1'b0};
        pend1 = '{1, 32'd0, 1'b0};

        // Both requesters are already valid while reset is held.
        applyStimulus(0, 4'b0110, 32'd10, 32'd3, 32'd7, 1'b0);
        applyStimulus(1, 4'b1000, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req0_ready",  req0_ready,  1'b0);
        checkOutput("rst_req1_ready",  req1_ready,  1'b0);
        checkOutput("rst_resp0_valid", resp0_valid, 1'b0);
        checkOutput("rst_resp1_valid", resp1_valid, 1'b0);
        checkOutput("rst_resp0_data",  resp0_data,  32'd0);
        checkOutput("rst_resp1_data",  resp1_data,  32'd0);
        checkOutput("rst_alu_ctrl",    alu_ctrl,    4'b0010);
        checkOutput("rst_alu_a",       alu_a,       32'd0);
        checkOutput("rst_alu_b",       alu_b,       32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Continuous requests from both ports after reset: grants alternate 0,1,0,1.
        fork
            begin
                waitGrant(0, 20);
                applyStimulus(0, 4'b0110, 32'd10, 32'd3, 32'd7, 1'b0);
                waitGrant(0, 20);
            end
            begin
                waitGrant(1, 20);
                applyStimulus(1, 4'b1000, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0);
                waitGrant(1, 20);
            end
        join
        waitDrain(20);
        checkOutput("alt_count", grantLog.size(), 4);
        if (grantLog.size() >= 4) begin
            checkOutput("alt_grant0", grantLog[0], 0);
            checkOutput("alt_grant1", grantLog[1], 1);
            checkOutput("alt_grant2", grantLog[2], 0);
            checkOutput("alt_grant3", grantLog[3], 1);
        end
        grantLog.delete();

        // Table vectors, one transaction each. The ALU inputs are checked in EXEC.
        for (int i = 0; i < 12; i++) begin
            vec_t v;
            v = vecs[i];
            applyStimulus(v.port, v.ctrl, v.a, v.b, v.exp, v.err);
            waitGrant(v.port, 10);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_alu_ctrl", i), alu_ctrl, v.ctrl);
            checkOutput($sformatf("vec%0d_alu_a", i), alu_a, v.a);
            checkOutput($sformatf("vec%0d_alu_b", i), alu_b, v.b);
            waitDrain(10);
            checkOutput($sformatf("vec%0d_hold", i), v.port == 0 ? resp0_data : resp1_data, v.exp);
        end
        grantLog.delete();

        // Port 1 stalls its response for 5 cycles while port 0 waits.
        resp1_ready = 1'b0;
        applyStimulus(1, 4'b0010, 32'd100, 32'd23, 32'd123, 1'b0);
        waitGrant(1, 10);
        applyStimulus(0, 4'b0011, 32'd3, 32'd5, 32'd6, 1'b0);
        for (int i = 0; i < 10 && !resp1_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_resp1_valid", resp1_valid, 1'b1);
            checkOutput("stall_resp1_data",  resp1_data,  32'd123);
            checkOutput("stall_req0_ready",  req0_ready,  1'b0);
            checkOutput("stall_resp0_valid", resp0_valid, 1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 resp1_ready = 1'b1;
        waitGrant(0, 10);
        waitDrain(10);
        checkGrantOrder("stall_order", 1, 0);

        // Reset during EXEC: the operation is dropped and priority returns to port 0.
        applyStimulus(0, 4'b0010, 32'd1, 32'd2, 32'd3, 1'b0);
        waitGrant(0, 10);
        applyStimulus(1, 4'b0001, 32'd8, 32'd1, 32'd9, 1'b0);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_resp0_valid", resp0_valid, 1'b0);
        checkOutput("midrst_resp1_valid", resp1_valid, 1'b0);
        checkOutput("midrst_req1_ready",  req1_ready,  1'b0);
        checkOutput("midrst_alu_ctrl",    alu_ctrl,    4'b0010);
        sbQ.delete();
        grantLog.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
        applyStimulus(0, 4'b0000, 32'h0000_00FF, 32'h0000_000F, 32'h0000_000F, 1'b0);
        fork
            waitGrant(0, 20);
            waitGrant(1, 20);
        join
        waitDrain(20);
        checkGrantOrder("midrst_order", 0, 1);

        // SETTLE=4: the ALU inputs stay stable for 4 EXEC cycles, and the result appears in cycle 5.
        s4_req1_ctrl  = 4'b1001;
        s4_req1_a     = 32'h8000_0000;
        s4_req1_b     = 32'd4;
        s4_req1_valid = 1'b1;
        begin
            bit got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                @(negedge clk);
                if (s4_req1_ready) got = 1'b1;
            end
            checkOutput("s4_grant", got, 1'b1);
        end
        @(posedge clk);
        #1 s4_req1_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("s4_c%0d_alu_ctrl", c), s4_alu_ctrl, 4'b1001);
            checkOutput($sformatf("s4_c%0d_alu_a", c), s4_alu_a, 32'h8000_0000);
            checkOutput($sformatf("s4_c%0d_alu_b", c), s4_alu_b, 32'd4);
            checkOutput($sformatf("s4_c%0d_resp1_valid", c), s4_resp1_valid, 1'b0);
            checkOutput($sformatf("s4_c%0d_req0_ready", c), s4_req0_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("s4_c5_resp1_valid", s4_resp1_valid, 1'b1);
        checkOutput("s4_c5_resp1_data",  s4_resp1_data,  32'hF800_0000);
        checkOutput("s4_c5_resp0_valid", s4_resp0_valid, 1'b0);
        checkOutput("s4_c5_resp0_data",  s4_resp0_data,  32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("s4_after_resp1_valid", s4_resp1_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
